clock_reset_sequencer: RTL

- Consumes the PLL lock outputs of the clock generation block: the 135MHz pixel-clock lock and the 108MHz SDRAM-clock lock.
- Produces ordered, active-high reset releases for the SDRAM controller, the video/HDMI pipeline and the audio path, plus a system-ready flag.
- Runs in the buffered 27MHz domain.
- Re-sequences from scratch on any loss of PLL lock.

---
 rtl/clock_reset_sequencer_pkg.sv | 12 +
 rtl/clock_reset_sequencer_sync_2ff.sv | 19 +
 rtl/clock_reset_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/clock_reset_sequencer_pkg.sv
// clock_reset_sequencer_pkg: shared state encoding and widths for the reset sequencer
package clock_reset_sequencer_pkg;
  localparam int ST_W = 3;
  localparam int LLC_W = 8;
  typedef enum logic [ST_W-1:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_REL_SDRAM = 3'd2,
    ST_REL_VIDEO = 3'd3,
    ST_RUN       = 3'd4
  } seq_state_e;
endpackage

// File: rtl/clock_reset_sequencer_sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser with synchronous active-high reset
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/clock_reset_sequencer.sv
// clock_reset_sequencer: orders SDRAM, video and audio reset releases after both PLLs lock
module clock_reset_sequencer
  import clock_reset_sequencer_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 27000,
  parameter int SDRAM_INIT_TIMEOUT = 5400,
  parameter int RELEASE_GAP = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_135_lock,
  input  logic             clk_sdram_lock,
  input  logic             sdram_init_done,
  output logic             sdram_rst,
  output logic             video_rst,
  output logic             audio_rst,
  output logic             sys_ready,
  output logic             init_timeout,
  output logic [LLC_W-1:0] lock_loss_count,
  output logic [ST_W-1:0]  seq_state
);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(SDRAM_INIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RELEASE_GAP - 1);
  logic lock_135, lock_sdram, locks_ok, lost;
  seq_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sdram_rst_q, sdram_rst_d, video_rst_q, video_rst_d;
  logic audio_rst_q, audio_rst_d, sys_ready_q, sys_ready_d;
  logic init_timeout_q, init_timeout_d;
  logic [LLC_W-1:0] llc_q, llc_d;
  sync_2ff u_sync_135 (.clk(clk), .reset(reset), .d(clk_135_lock), .q(lock_135));
  sync_2ff u_sync_sdram (.clk(clk), .reset(reset), .d(clk_sdram_lock), .q(lock_sdram));
  assign locks_ok = lock_135 & lock_sdram;
  assign lost = !locks_ok && (state_q inside {ST_REL_SDRAM, ST_REL_VIDEO, ST_RUN});
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    init_timeout_d = init_timeout_q;
    llc_d = llc_q;
    case (state_q)
      ST_HOLD: begin
        state_d = ST_WAIT_LOCK;
        cnt_d = '0;
      end
      ST_WAIT_LOCK: begin
        cnt_d = locks_ok ? cnt_q + 1'b1 : '0;
        if (locks_ok && cnt_q == LOCK_LAST) begin
          state_d = ST_REL_SDRAM;
          cnt_d = '0;
        end
      end
      ST_REL_SDRAM: begin
        cnt_d = cnt_q + 1'b1;
        if (sdram_init_done) begin
          state_d = ST_REL_VIDEO;
          cnt_d = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_REL_VIDEO;
          init_timeout_d = 1'b1;
          cnt_d = '0;
        end
      end
      ST_REL_VIDEO: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) begin
          state_d = ST_RUN;
          cnt_d = '0;
        end
      end
      ST_RUN: cnt_d = '0;
      default: begin
        state_d = ST_HOLD;
        cnt_d = '0;
      end
    endcase
    if (lost) begin
      state_d = ST_HOLD;
      cnt_d = '0;
      init_timeout_d = init_timeout_q;
      llc_d = &llc_q ? llc_q : llc_q + 1'b1;
    end
    sdram_rst_d = !(state_d inside {ST_REL_SDRAM, ST_REL_VIDEO, ST_RUN});
    video_rst_d = !(state_d inside {ST_REL_VIDEO, ST_RUN});
    audio_rst_d = state_d != ST_RUN;
    sys_ready_d = state_d == ST_RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HOLD;
      cnt_q <= '0;
      sdram_rst_q <= 1'b1;
      video_rst_q <= 1'b1;
      audio_rst_q <= 1'b1;
      sys_ready_q <= 1'b0;
      init_timeout_q <= 1'b0;
      llc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sdram_rst_q <= sdram_rst_d;
      video_rst_q <= video_rst_d;
      audio_rst_q <= audio_rst_d;
      sys_ready_q <= sys_ready_d;
      init_timeout_q <= init_timeout_d;
      llc_q <= llc_d;
    end
  end
  assign sdram_rst = sdram_rst_q;
  assign video_rst = video_rst_q;
  assign audio_rst = audio_rst_q;
  assign sys_ready = sys_ready_q;
  assign init_timeout = init_timeout_q;
  assign lock_loss_count = llc_q;
  assign seq_state = state_q;
endmodule
